// File: rtl/pc_gen_unit.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, redirects, alignment trap and a saturating redirect counter.
// Build option: define PC_COMPRESSED_EN to relax the ALU-target alignment rule to 2-byte.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_ready,
    input  logic [1:0]       pc_sel,
    input  logic [XLEN-1:0]  alu_in,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic [XLEN-1:0]  epc_in,
    input  logic             halt_req,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             pc_valid,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc_next;
    logic            misalign_next;
    logic            take_redirect;
    logic            alu_misaligned;

`ifdef PC_COMPRESSED_EN
    assign alu_misaligned = alu_in[0];
`else
    assign alu_misaligned = |alu_in[1:0];
`endif

    assign pc_plus4 = pc + XLEN'(4);
    assign pc_valid = (state == RUN);

    // A halt request in RUN suppresses any pending redirect or sequential advance.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        misalign_next = 1'b0;
        take_redirect = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (halt_req) begin
                    state_next = HALT;
                end else begin
                    case (pc_sel)
                        2'b00: begin
                            if (if_ready) begin
                                pc_next = pc_plus4;
                            end
                        end
                        2'b01: begin
                            take_redirect = 1'b1;
                            if (alu_misaligned) begin
                                pc_next       = trap_vec;
                                misalign_next = 1'b1;
                            end else begin
                                pc_next = alu_in;
                            end
                        end
                        2'b10: begin
                            take_redirect = 1'b1;
                            pc_next       = trap_vec;
                        end
                        default: begin
                            take_redirect = 1'b1;
                            pc_next       = epc_in;
                        end
                    endcase
                end
            end
            HALT: begin
                if (!halt_req) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            misalign_exc <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            misalign_exc <= misalign_next;
            if (take_redirect && (redirect_cnt != {CNT_W{1'b1}})) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end

endmodule
